// File: rtl/sdrd_sector_arbiter.sv
// Shares one SPI sector-read engine between the FAT32 walker (requester 0) and the
// image streamer (requester 1): fixed priority to 0, with a streak limit that protects 1.
module sdrd_sector_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter int unsigned MAX_STREAK     = 4
) (
  input  logic        CLK,
  input  logic        RST_X,
  input  logic        SPI_INIT,
  input  logic        SPI_BUSY,
  input  logic        SPI_SECWR,
  input  logic        R0_REQ,
  input  logic [31:0] R0_ADR,
  input  logic [31:0] R0_SIZE,
  input  logic [1:0]  R0_TYPE,
  input  logic        R1_REQ,
  input  logic [31:0] R1_ADR,
  input  logic [31:0] R1_SIZE,
  input  logic [1:0]  R1_TYPE,
  output logic        R0_ACK,
  output logic        R1_ACK,
  output logic        R0_SECWR,
  output logic        R1_SECWR,
  output logic        R0_DONE,
  output logic        R1_DONE,
  output logic        R0_ERR,
  output logic        R1_ERR,
  output logic [31:0] ACC_ADR,
  output logic [31:0] ACC_SIZE,
  output logic [1:0]  ACC_TYPE,
  output logic        ACC_START,
  output logic [1:0]  GRANT
);

  localparam int unsigned TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int unsigned ST_W = (MAX_STREAK > 0) ? $clog2(MAX_STREAK + 1) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [ST_W-1:0] ST_MAX  = ST_W'(MAX_STREAK);

  typedef enum logic [2:0] {
    S_WAIT_INIT,
    S_IDLE,
    S_ISSUE,
    S_WAIT_BUSY,
    S_XFER,
    S_FINISH
  } state_e;

  state_e          state_q, state_d;
  logic [1:0]      grant_q, grant_d;
  logic [31:0]     acc_adr_q, acc_adr_d;
  logic [31:0]     acc_size_q, acc_size_d;
  logic [1:0]      acc_type_q, acc_type_d;
  logic [31:0]     sec_cnt_q, sec_cnt_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic [ST_W-1:0] streak_q, streak_d;
  logic [1:0]      abort_err_q, abort_err_d;

  logic [1:0]  ack;
  logic [1:0]  done;
  logic [1:0]  err;
  logic        acc_start;

  // Arbitration: requester 1 wins only when 0 is idle or 0 has used up its streak.
  logic        win_r1;
  logic        win_any;
  logic [1:0]  win_onehot;
  logic [31:0] win_adr;
  logic [31:0] win_size;
  logic [1:0]  win_type;

  assign win_r1     = R1_REQ && (!R0_REQ || (streak_q == ST_MAX));
  assign win_any    = R0_REQ || R1_REQ;
  assign win_onehot = win_r1 ? 2'b10 : 2'b01;
  assign win_adr    = win_r1 ? R1_ADR  : R0_ADR;
  assign win_size   = win_r1 ? R1_SIZE : R0_SIZE;
  assign win_type   = win_r1 ? R1_TYPE : R0_TYPE;

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
    state_d     = state_q;
    grant_d     = grant_q;
    acc_adr_d   = acc_adr_q;
    acc_size_d  = acc_size_q;
    acc_type_d  = acc_type_q;
    sec_cnt_d   = sec_cnt_q;
    to_cnt_d    = to_cnt_q;
    streak_d    = streak_q;
    abort_err_d = 2'b00;
    ack         = 2'b00;
    done        = 2'b00;
    err         = 2'b00;
    acc_start   = 1'b0;

    unique case (state_q)
      S_WAIT_INIT: begin
        if (SPI_INIT) state_d = S_IDLE;
      end

      S_IDLE: begin
        if (SPI_INIT && win_any) begin
          if (win_r1 || !R1_REQ) streak_d = '0;
          else                   streak_d = streak_q + ST_W'(1);

          if (win_size == 32'd0) begin
            ack = win_onehot;
            err = win_onehot;
          end else begin
            acc_adr_d  = win_adr;
            acc_size_d = win_size;
            acc_type_d = win_type;
            grant_d    = win_onehot;
            state_d    = S_ISSUE;
          end
        end
      end

      S_ISSUE: begin
        acc_start = 1'b1;
        ack       = grant_q;
        sec_cnt_d = '0;
        to_cnt_d  = '0;
        state_d   = S_WAIT_BUSY;
      end

      S_WAIT_BUSY: begin
        if (SPI_BUSY) begin
          state_d = S_XFER;
        end else if (to_cnt_q == TO_LAST) begin
          err     = grant_q;
          grant_d = 2'b00;
          state_d = S_IDLE;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end

      S_XFER: begin
        // A strobe on the same cycle BUSY falls is still counted before FINISH compares.
        if (SPI_SECWR && (sec_cnt_q != '1)) sec_cnt_d = sec_cnt_q + 32'd1;
        if (!SPI_BUSY) state_d = S_FINISH;
      end

      S_FINISH: begin
        if (sec_cnt_q == acc_size_q) done = grant_q;
        else                         err  = grant_q;
        grant_d = 2'b00;
        state_d = S_IDLE;
      end

      default: state_d = S_WAIT_INIT;
    endcase

    // Losing card init overrides everything; the owner hears about it one cycle later.
    if ((state_q != S_WAIT_INIT) && !SPI_INIT) begin
      abort_err_d = grant_q;
      grant_d     = 2'b00;
      done        = 2'b00;
      err         = 2'b00;
      state_d     = S_WAIT_INIT;
    end
  end

  // NOTE: reset is synchronous and clears every register, including the ACC_* holding registers.
  always_ff @(posedge CLK) begin
    if (!RST_X) begin
      state_q     <= S_WAIT_INIT;
      grant_q     <= 2'b00;
      acc_adr_q   <= '0;
      acc_size_q  <= '0;
      acc_type_q  <= '0;
      sec_cnt_q   <= '0;
      to_cnt_q    <= '0;
      streak_q    <= '0;
      abort_err_q <= 2'b00;
    end else begin
      // NOTE: non-blocking assignments so every register samples the pre-edge _d values.
      state_q     <= state_d;
      grant_q     <= grant_d;
      acc_adr_q   <= acc_adr_d;
      acc_size_q  <= acc_size_d;
      acc_type_q  <= acc_type_d;
      sec_cnt_q   <= sec_cnt_d;
      to_cnt_q    <= to_cnt_d;
      streak_q    <= streak_d;
      abort_err_q <= abort_err_d;
    end
  end

  assign R0_ACK    = ack[0];
  assign R1_ACK    = ack[1];
  assign R0_DONE   = done[0];
  assign R1_DONE   = done[1];
  assign R0_ERR    = err[0] | abort_err_q[0];
  assign R1_ERR    = err[1] | abort_err_q[1];
  assign R0_SECWR  = SPI_SECWR & grant_q[0] & (state_q == S_XFER);
  assign R1_SECWR  = SPI_SECWR & grant_q[1] & (state_q == S_XFER);
  assign ACC_ADR   = acc_adr_q;
  assign ACC_SIZE  = acc_size_q;
  assign ACC_TYPE  = acc_type_q;
  assign ACC_START = acc_start;
  assign GRANT     = grant_q;

endmodule

// File: tb/tb_sdrd_sector_arbiter.sv
// Self-checking bench for sdrd_sector_arbiter: directed scenarios plus a randomized
// run scored against a transaction-level model of arbitration and outcome.
module tb_sdrd_sector_arbiter;

  localparam int unsigned TO = 16;
  localparam int unsigned MS = 4;

  logic        CLK = 1'b0;
  logic        RST_X, SPI_INIT, SPI_BUSY, SPI_SECWR;
  logic        R0_REQ, R1_REQ;
  logic [31:0] R0_ADR, R1_ADR, R0_SIZE, R1_SIZE;
  logic [1:0]  R0_TYPE, R1_TYPE;
  logic        R0_ACK, R1_ACK, R0_SECWR, R1_SECWR, R0_DONE, R1_DONE, R0_ERR, R1_ERR;
  logic [31:0] ACC_ADR, ACC_SIZE;
  logic [1:0]  ACC_TYPE, GRANT;
  logic        ACC_START;

  sdrd_sector_arbiter #(.TIMEOUT_CYCLES(TO), .MAX_STREAK(MS)) dut (
    .CLK(CLK), .RST_X(RST_X), .SPI_INIT(SPI_INIT), .SPI_BUSY(SPI_BUSY), .SPI_SECWR(SPI_SECWR),
    .R0_REQ(R0_REQ), .R0_ADR(R0_ADR), .R0_SIZE(R0_SIZE), .R0_TYPE(R0_TYPE),
    .R1_REQ(R1_REQ), .R1_ADR(R1_ADR), .R1_SIZE(R1_SIZE), .R1_TYPE(R1_TYPE),
    .R0_ACK(R0_ACK), .R1_ACK(R1_ACK), .R0_SECWR(R0_SECWR), .R1_SECWR(R1_SECWR),
    .R0_DONE(R0_DONE), .R1_DONE(R1_DONE), .R0_ERR(R0_ERR), .R1_ERR(R1_ERR),
    .ACC_ADR(ACC_ADR), .ACC_SIZE(ACC_SIZE), .ACC_TYPE(ACC_TYPE),
    .ACC_START(ACC_START), .GRANT(GRANT)
  );

  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;

  // Event monitor: tallies output pulses at each falling edge.
  int          cyc = 0;
  int          n_ack[2], n_err[2], n_done[2], n_secwr[2];
  int          last_ack_cyc[2], last_err_cyc[2];
  int          n_start, last_start_cyc, n_both;
  logic [31:0] st_adr, st_size;
  logic [1:0]  st_type;
  int          ack_log[$];

  always @(negedge CLK) begin
    cyc++;
    if (R0_ACK)   begin n_ack[0]++; last_ack_cyc[0] = cyc; ack_log.push_back(0); end
    if (R1_ACK)   begin n_ack[1]++; last_ack_cyc[1] = cyc; ack_log.push_back(1); end
    if (R0_ERR)   begin n_err[0]++; last_err_cyc[0] = cyc; end
    if (R1_ERR)   begin n_err[1]++; last_err_cyc[1] = cyc; end
    if (R0_DONE)  n_done[0]++;
    if (R1_DONE)  n_done[1]++;
    if (R0_SECWR) n_secwr[0]++;
    if (R1_SECWR) n_secwr[1]++;
    if ((R0_DONE && R0_ERR) || (R1_DONE && R1_ERR)) n_both++;
    if (ACC_START) begin
      n_start++;
      last_start_cyc = cyc;
      st_adr  = ACC_ADR;
      st_size = ACC_SIZE;
      st_type = ACC_TYPE;
    end
  end

  function automatic logic [10:0] out_vec();
    return {R0_ACK, R1_ACK, R0_SECWR, R1_SECWR, R0_DONE, R1_DONE, R0_ERR, R1_ERR, ACC_START, GRANT};
  endfunction

  task automatic clear_counts();
    for (int i = 0; i < 2; i++) begin
      n_ack[i] = 0; n_err[i] = 0; n_done[i] = 0; n_secwr[i] = 0;
      last_ack_cyc[i] = -1; last_err_cyc[i] = -1;
    end
    n_start = 0;
    last_start_cyc = -1;
    ack_log.delete();
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic settle();
    @(negedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST_X = 1'b0; SPI_INIT = 1'b0; SPI_BUSY = 1'b0; SPI_SECWR = 1'b0;
    R0_REQ = 1'b0; R1_REQ = 1'b0;
    tick(); tick(); tick();
    RST_X = 1'b1; SPI_INIT = 1'b1;
    tick(); tick();
    clear_counts();
  endtask

  task automatic wait_start(input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      settle();
      if (ACC_START === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // SPI engine model: called right after the ACC_START cycle; ends in the IDLE cycle after FINISH.
  task automatic spi_xfer(input int n_before, input bit at_fall, input bit stray);
    tick(); SPI_BUSY = 1'b1; SPI_SECWR = stray;
    tick(); SPI_SECWR = 1'b0;
    for (int i = 0; i < n_before; i++) begin
      tick(); SPI_SECWR = 1'b1;
      tick(); SPI_SECWR = 1'b0;
    end
    tick(); SPI_BUSY = 1'b0; SPI_SECWR = at_fall;
    tick(); SPI_SECWR = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    RST_X = 1'b0; SPI_INIT = 1'b1; SPI_BUSY = 1'b1; SPI_SECWR = 1'b1;
    R0_REQ = 1'b1; R1_REQ = 1'b1;
    R0_ADR = 32'h55; R0_SIZE = 32'd2; R0_TYPE = 2'd1;
    R1_ADR = 32'h66; R1_SIZE = 32'd2; R1_TYPE = 2'd2;
    tick(); tick(); tick();
    settle();
    n_tests++;
    if (out_vec() !== 11'd0) begin
      n_fail++; $display("FAIL reset_outputs got=%b want=%b", out_vec(), 11'd0);
    end
    n_tests++;
    if ({ACC_ADR, ACC_SIZE, ACC_TYPE} !== 66'd0) begin
      n_fail++; $display("FAIL reset_acc got=%h/%h/%h want=0/0/0", ACC_ADR, ACC_SIZE, ACC_TYPE);
    end
  endtask

  task automatic test_power_up();
    bit ok;
    int init_cyc;
    SPI_INIT = 1'b0; SPI_BUSY = 1'b0; SPI_SECWR = 1'b0; R1_REQ = 1'b0;
    R0_REQ = 1'b1; R0_ADR = 32'h0000_2000; R0_SIZE = 32'd1; R0_TYPE = 2'd2;
    tick();
    RST_X = 1'b1;
    clear_counts();
    repeat (50) tick();
    n_tests++;
    if (n_start != 0 || n_ack[0] != 0) begin
      n_fail++; $display("FAIL powerup_no_start got starts=%0d acks=%0d want 0/0", n_start, n_ack[0]);
    end
    SPI_INIT = 1'b1;
    init_cyc = cyc + 1;
    wait_start(8, ok);
    R0_REQ = 1'b0;
    n_tests++;
    if (!ok || last_start_cyc != init_cyc + 2) begin
      n_fail++; $display("FAIL powerup_latency got=%0d want=%0d", last_start_cyc - init_cyc, 2);
    end
    n_tests++;
    if (st_adr !== 32'h0000_2000) begin
      n_fail++; $display("FAIL powerup_adr got=%h want=%h", st_adr, 32'h0000_2000);
    end
    if (ok) spi_xfer(1, 1'b0, 1'b0);
    n_tests++;
    if (n_done[0] != 1) begin
      n_fail++; $display("FAIL powerup_done got=%0d want=1", n_done[0]);
    end
  endtask

  task automatic test_r1_single();
    bit ok;
    do_reset();
    R1_ADR = 32'h1234; R1_SIZE = 32'd3; R1_TYPE = 2'd1;
    tick(); R1_REQ = 1'b1;
    wait_start(4, ok);
    R1_REQ = 1'b0;
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL r1_start got=none want=ACC_START"); end
    else spi_xfer(3, 1'b0, 1'b0);
    n_tests++;
    if (n_secwr[1] != 3 || n_secwr[0] != 0) begin
      n_fail++; $display("FAIL r1_secwr got r1=%0d r0=%0d want 3/0", n_secwr[1], n_secwr[0]);
    end
    n_tests++;
    if (n_done[1] != 1 || n_err[1] != 0) begin
      n_fail++; $display("FAIL r1_done got done=%0d err=%0d want 1/0", n_done[1], n_err[1]);
    end
    n_tests++;
    if (ACC_ADR !== 32'h1234 || GRANT !== 2'b00) begin
      n_fail++; $display("FAIL r1_hold got adr=%h grant=%b want 1234/00", ACC_ADR, GRANT);
    end
  endtask

  task automatic test_starvation();
    bit ok;
    int streak;
    int exp_seq[6];
    do_reset();
    streak = 0;
    for (int k = 0; k < 6; k++) begin
      exp_seq[k] = (streak == int'(MS)) ? 1 : 0;
      streak = (exp_seq[k] == 1) ? 0 : streak + 1;
    end
    R0_ADR = 32'h10; R0_SIZE = 32'd1; R0_TYPE = 2'd0;
    R1_ADR = 32'h20; R1_SIZE = 32'd1; R1_TYPE = 2'd3;
    tick(); R0_REQ = 1'b1; R1_REQ = 1'b1;
    for (int k = 0; k < 6; k++) begin
      wait_start(4, ok);
      if (!ok) break;
      spi_xfer(1, 1'b0, 1'b0);
    end
    R0_REQ = 1'b0; R1_REQ = 1'b0;
    tick(); tick();
    for (int k = 0; k < 6; k++) begin
      int got;
      got = (k < ack_log.size()) ? ack_log[k] : -1;
      n_tests++;
      if (got != exp_seq[k]) begin
        n_fail++; $display("FAIL starve_grant%0d got=R%0d want=R%0d", k, got, exp_seq[k]);
      end
    end
  endtask

  task automatic test_count_mismatch();
    bit ok;
    do_reset();
    R0_ADR = 32'h300; R0_SIZE = 32'd4; R0_TYPE = 2'd0;
    tick(); R0_REQ = 1'b1;
    wait_start(4, ok);
    R0_REQ = 1'b0;
    if (ok) spi_xfer(2, 1'b0, 1'b0);
    n_tests++;
    if (!ok || n_err[0] != 1 || n_done[0] != 0) begin
      n_fail++; $display("FAIL mismatch got err=%0d done=%0d want 1/0", n_err[0], n_done[0]);
    end
    clear_counts();
    R1_SIZE = 32'd0; R1_ADR = 32'h77;
    tick(); R1_REQ = 1'b1;
    tick(); R1_REQ = 1'b0;
    tick(); tick(); tick();
    n_tests++;
    if (n_ack[1] != 1 || n_err[1] != 1 || last_ack_cyc[1] != last_err_cyc[1]) begin
      n_fail++; $display("FAIL zero_size got ack=%0d err=%0d ackcyc=%0d errcyc=%0d want 1/1/same",
                         n_ack[1], n_err[1], last_ack_cyc[1], last_err_cyc[1]);
    end
    n_tests++;
    if (n_start != 0 || GRANT !== 2'b00) begin
      n_fail++; $display("FAIL zero_size_nostart got starts=%0d grant=%b want 0/00", n_start, GRANT);
    end
  endtask

  task automatic test_timeout();
    bit ok;
    bit seen;
    do_reset();
    R0_ADR = 32'h400; R0_SIZE = 32'd2; R0_TYPE = 2'd1;
    tick(); R0_REQ = 1'b1;
    wait_start(4, ok);
    R0_REQ = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      settle();
      if (n_err[0] != 0) begin seen = 1'b1; break; end
    end
    n_tests++;
    if (!ok || !seen || last_err_cyc[0] - last_start_cyc != int'(TO)) begin
      n_fail++; $display("FAIL timeout_delay got=%0d want=%0d", last_err_cyc[0] - last_start_cyc, TO);
    end
    settle();
    n_tests++;
    if (GRANT !== 2'b00) begin
      n_fail++; $display("FAIL timeout_grant got=%b want=00", GRANT);
    end
    clear_counts();
    R1_ADR = 32'h500; R1_SIZE = 32'd1; R1_TYPE = 2'd2;
    tick(); R1_REQ = 1'b1;
    wait_start(4, ok);
    R1_REQ = 1'b0;
    if (ok) spi_xfer(1, 1'b0, 1'b0);
    n_tests++;
    if (!ok || n_done[1] != 1) begin
      n_fail++; $display("FAIL timeout_next got done=%0d want=1", n_done[1]);
    end
  endtask

  task automatic test_abort();
    bit ok;
    int low_cyc;
    do_reset();
    R0_ADR = 32'h600; R0_SIZE = 32'd3; R0_TYPE = 2'd0;
    tick(); R0_REQ = 1'b1;
    wait_start(4, ok);
    R0_REQ = 1'b0;
    tick(); SPI_BUSY = 1'b1;
    tick();
    tick(); SPI_SECWR = 1'b1;
    tick(); SPI_SECWR = 1'b0;
    tick(); SPI_INIT = 1'b0; R0_REQ = 1'b1;
    low_cyc = cyc + 1;
    settle(); settle();
    n_tests++;
    if (!ok || n_err[0] != 1 || last_err_cyc[0] != low_cyc + 1) begin
      n_fail++; $display("FAIL abort_err got n=%0d at=%0d want 1 at %0d", n_err[0], last_err_cyc[0], low_cyc + 1);
    end
    repeat (5) settle();
    n_tests++;
    if (n_start != 1 || n_done[0] != 0 || GRANT !== 2'b00) begin
      n_fail++; $display("FAIL abort_waitinit got starts=%0d done=%0d grant=%b want 1/0/00", n_start, n_done[0], GRANT);
    end
    R0_REQ = 1'b0; SPI_BUSY = 1'b0;
  endtask

  task automatic test_reset_mid_xfer();
    bit ok;
    do_reset();
    R1_ADR = 32'h700; R1_SIZE = 32'd3; R1_TYPE = 2'd3;
    tick(); R1_REQ = 1'b1;
    wait_start(4, ok);
    R1_REQ = 1'b0;
    tick(); SPI_BUSY = 1'b1;
    tick();
    tick(); SPI_SECWR = 1'b1; RST_X = 1'b0; R1_REQ = 1'b1;
    settle(); settle();
    n_tests++;
    if (!ok || out_vec() !== 11'd0 || {ACC_ADR, ACC_SIZE, ACC_TYPE} !== 66'd0) begin
      n_fail++; $display("FAIL rst_mid got out=%b adr=%h want all zero", out_vec(), ACC_ADR);
    end
    repeat (4) settle();
    n_tests++;
    if (n_err[1] != 0 || n_ack[1] != 1) begin
      n_fail++; $display("FAIL rst_mid_noerr got err=%0d ack=%0d want 0/1", n_err[1], n_ack[1]);
    end
    SPI_SECWR = 1'b0; SPI_BUSY = 1'b0; R1_REQ = 1'b0;
  endtask

  task automatic test_random();
    int streak;
    do_reset();
    streak = 0;
    for (int it = 0; it < 40; it++) begin
      bit ok, r0, r1, at_fall, stray;
      int win, dmode, delivered, n_before, exp_done, exp_err;
      logic [31:0] wadr, wsize;
      logic [1:0]  wtype;
      r0 = 1'($urandom_range(0, 1));
      r1 = 1'($urandom_range(0, 1));
      if (!r0 && !r1) r0 = 1'b1;
      R0_ADR = $urandom; R0_SIZE = 32'($urandom_range(0, 4)); R0_TYPE = 2'($urandom_range(0, 3));
      R1_ADR = $urandom; R1_SIZE = 32'($urandom_range(0, 4)); R1_TYPE = 2'($urandom_range(0, 3));

      win = (r1 && (!r0 || streak == int'(MS))) ? 1 : 0;
      streak = (win == 1 || !r1) ? 0 : streak + 1;
      wadr  = win ? R1_ADR  : R0_ADR;
      wsize = win ? R1_SIZE : R0_SIZE;
      wtype = win ? R1_TYPE : R0_TYPE;

      dmode = int'($urandom_range(0, 2));
      delivered = int'(wsize);
      if (dmode == 1) delivered = int'(wsize) + 1;
      else if (dmode == 2 && wsize != 0) delivered = int'(wsize) - 1;
      at_fall  = (delivered > 0) ? 1'($urandom_range(0, 1)) : 1'b0;
      n_before = delivered - int'(at_fall);
      stray    = 1'($urandom_range(0, 1));
      exp_done = (wsize != 0 && delivered == int'(wsize)) ? 1 : 0;
      exp_err  = 1 - exp_done;

      clear_counts();
      tick(); R0_REQ = r0; R1_REQ = r1;
      if (wsize == 0) begin
        tick(); R0_REQ = 1'b0; R1_REQ = 1'b0;
        tick(); tick();
      end else begin
        wait_start(4, ok);
        R0_REQ = 1'b0; R1_REQ = 1'b0;
        if (ok) spi_xfer(n_before, at_fall, stray);
        else tick();
      end

      n_tests++;
      if (n_ack[win] != 1 || n_ack[1-win] != 0 || n_start != ((wsize != 0) ? 1 : 0)) begin
        n_fail++; $display("FAIL rand%0d_grant got ack0=%0d ack1=%0d starts=%0d want winner R%0d",
                           it, n_ack[0], n_ack[1], n_start, win);
      end
      if (wsize != 0) begin
        n_tests++;
        if ({st_adr, st_size, st_type} !== {wadr, wsize, wtype}) begin
          n_fail++; $display("FAIL rand%0d_acc got=%h/%h/%h want=%h/%h/%h",
                             it, st_adr, st_size, st_type, wadr, wsize, wtype);
        end
        n_tests++;
        if (n_secwr[win] != delivered || n_secwr[1-win] != 0) begin
          n_fail++; $display("FAIL rand%0d_secwr got owner=%0d other=%0d want %0d/0",
                             it, n_secwr[win], n_secwr[1-win], delivered);
        end
      end
      n_tests++;
      if (n_done[win] != exp_done || n_err[win] != exp_err || n_done[1-win] != 0 || n_err[1-win] != 0) begin
        n_fail++; $display("FAIL rand%0d_result got done=%0d err=%0d other=%0d/%0d want %0d/%0d",
                           it, n_done[win], n_err[win], n_done[1-win], n_err[1-win], exp_done, exp_err);
      end
    end
  endtask

  task automatic test_exclusive_outcome();
    n_tests++;
    if (n_both != 0) begin
      n_fail++; $display("FAIL done_err_overlap got=%0d want=0", n_both);
    end
  endtask

  initial begin
    n_both = 0;
    clear_counts();
    test_reset();
    test_power_up();
    test_r1_single();
    test_starvation();
    test_count_mismatch();
    test_timeout();
    test_abort();
    test_reset_mid_xfer();
    test_random();
    test_exclusive_outcome();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
